// File: rtl/blood_abnormality_monitor_pkg.sv
// Shared definitions for the blood abnormality monitor: FSM state codes and default parameters.
// Latency: n/a (constants only).
// Backpressure: n/a.
package blood_abnormality_monitor_pkg;

   // monState encoding; bit 1 set means the debounced alarm is active
   localparam logic [1:0] MON_NORMAL  = 2'd0;
   localparam logic [1:0] MON_SUSPECT = 2'd1;
   localparam logic [1:0] MON_ALARM   = 2'd2;
   localparam logic [1:0] MON_RECOVER = 2'd3;

   localparam int DEF_ASSERT_N = 3;
   localparam int DEF_CLEAR_M  = 2;
   localparam int DEF_RUN_W    = 4;
   localparam int DEF_CNT_W    = 8;

endpackage

// File: rtl/blood_abnormality_monitor_sat_counter.sv
// Saturating up-counter: increments by one when i_en is high, sticks at all-ones.
// Latency: 1 cycle from i_en to updated o_count.
// Backpressure: none; every enable is counted until saturation.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   output logic [W-1:0] o_count
);

   localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
   localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] r_count;

   // count enabled events, holding at MAX_VAL instead of wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_en && (r_count != MAX_VAL)) begin
         r_count <= r_count + ONE;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/blood_abnormality_monitor.sv
// Debounces the detector's abnormality flag into an alarm level, plus sticky latch and episode count.
// Latency: 1 cycle; a sample accepted at edge t is reflected on all outputs right after that edge.
// Backpressure: none; every sampleValid pulse is consumed, back-to-back included.
module blood_abnormality_monitor
   import blood_abnormality_monitor_pkg::*;
#(
   parameter int ASSERT_N = DEF_ASSERT_N,
   parameter int CLEAR_M  = DEF_CLEAR_M,
   parameter int RUN_W    = DEF_RUN_W,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sampleValid,
   input  logic             bloodAbnormality,
   input  logic             alarmAck,
   output logic             alarm,
   output logic             alarmLatched,
   output logic [CNT_W-1:0] episodeCount,
   output logic [1:0]       monState
);

   localparam logic [RUN_W-1:0] RUN_ONE    = {{(RUN_W-1){1'b0}}, 1'b1};
   localparam logic [RUN_W-1:0] ASSERT_RUN = RUN_W'(ASSERT_N);
   localparam logic [RUN_W-1:0] CLEAR_RUN  = RUN_W'(CLEAR_M);

   logic [1:0]       r_state;
   logic [RUN_W-1:0] r_run;
   logic             r_latched;

   logic [1:0]       w_state_nxt;
   logic [RUN_W-1:0] w_run_nxt;
   logic [RUN_W-1:0] w_run_inc;
   logic             w_episode_start;

   assign w_run_inc = r_run + RUN_ONE;

   // next-state and run-length decode for one valid sample
   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
      case (r_state)
         MON_NORMAL: begin
            if (bloodAbnormality) begin
               w_run_nxt   = RUN_ONE;
               w_state_nxt = (ASSERT_N == 1) ? MON_ALARM : MON_SUSPECT;
            end else begin
               w_run_nxt   = '0;
            end
         end
         MON_SUSPECT: begin
            if (bloodAbnormality) begin
               w_run_nxt   = w_run_inc;
               w_state_nxt = (w_run_inc == ASSERT_RUN) ? MON_ALARM : MON_SUSPECT;
            end else begin
               w_run_nxt   = '0;
               w_state_nxt = MON_NORMAL;
            end
         end
         MON_ALARM: begin
            if (bloodAbnormality) begin
               w_run_nxt   = '0;
            end else begin
               w_run_nxt   = RUN_ONE;
               w_state_nxt = (CLEAR_M == 1) ? MON_NORMAL : MON_RECOVER;
            end
         end
         default: begin
            // MON_RECOVER: a relapse goes straight back to ALARM without a new episode
            if (bloodAbnormality) begin
               w_run_nxt   = '0;
               w_state_nxt = MON_ALARM;
            end else begin
               w_run_nxt   = w_run_inc;
               w_state_nxt = (w_run_inc == CLEAR_RUN) ? MON_NORMAL : MON_RECOVER;
            end
         end
      endcase
   end

   // an episode starts only when ALARM is entered from a non-alarm state
   assign w_episode_start = sampleValid && (w_state_nxt == MON_ALARM) &&
                            ((r_state == MON_NORMAL) || (r_state == MON_SUSPECT));

   // FSM state and run-length register, advanced only on valid samples
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= MON_NORMAL;
         r_run   <= '0;
      end else if (sampleValid) begin
         r_state <= w_state_nxt;
         r_run   <= w_run_nxt;
      end
   end

   // sticky alarm latch; a new episode beats a simultaneous acknowledge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_latched <= 1'b0;
      end else if (w_episode_start) begin
         r_latched <= 1'b1;
      end else if (alarmAck) begin
         r_latched <= 1'b0;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_episode_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_episode_start),
      .o_count (episodeCount)
   );

   assign alarm        = r_state[1];
   assign alarmLatched = r_latched;
   assign monState     = r_state;

endmodule

// File: tb/tb_blood_abnormality_monitor.sv
module tb_blood_abnormality_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sampleValid = 1'b0;
   logic       bloodAbnormality = 1'b0;
   logic       alarmAck = 1'b0;
   logic       alarm, alarmLatched;
   logic [7:0] episodeCount;
   logic [1:0] monState;
   logic       alarm2, alarmLatched2;
   logic [1:0] episodeCount2;
   logic [1:0] monState2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   blood_abnormality_monitor dut (
      .clk(clk), .rst(rst), .sampleValid(sampleValid), .bloodAbnormality(bloodAbnormality),
      .alarmAck(alarmAck), .alarm(alarm), .alarmLatched(alarmLatched),
      .episodeCount(episodeCount), .monState(monState)
   );

   blood_abnormality_monitor #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .sampleValid(sampleValid), .bloodAbnormality(bloodAbnormality),
      .alarmAck(alarmAck), .alarm(alarm2), .alarmLatched(alarmLatched2),
      .episodeCount(episodeCount2), .monState(monState2)
   );

   // apply one cycle of inputs at the falling edge, return just after the next rising edge
   task automatic drive(input logic v, input logic ab, input logic ack, input logic r);
      @(negedge clk);
      sampleValid = v;
      bloodAbnormality = ab;
      alarmAck = ack;
      rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      // rst must override a valid abnormal sample and an ack in the same cycle
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      n_cmp++; if (monState !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", monState); end
      n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
      n_cmp++; if (alarmLatched !== 1'b0) begin n_err++; $display("FAIL reset_latch got=%b exp=0", alarmLatched); end
      n_cmp++; if (episodeCount !== 8'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", episodeCount); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_st [3] = '{2'd1, 2'd1, 2'd2};
      logic       exp_al [3] = '{1'b0, 1'b0, 1'b1};
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0);
         n_cmp++; if (monState !== exp_st[i]) begin n_err++; $display("FAIL b2b_state[%0d] got=%0d exp=%0d", i, monState, exp_st[i]); end
         n_cmp++; if (alarm !== exp_al[i]) begin n_err++; $display("FAIL b2b_alarm[%0d] got=%b exp=%b", i, alarm, exp_al[i]); end
      end
      n_cmp++; if (alarmLatched !== 1'b1) begin n_err++; $display("FAIL b2b_latch got=%b exp=1", alarmLatched); end
      n_cmp++; if (episodeCount !== 8'd1) begin n_err++; $display("FAIL b2b_count got=%0d exp=1", episodeCount); end
   endtask

   task automatic test_interrupted_run();
      logic       ab_seq [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [1:0] exp_st [6] = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2};
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, ab_seq[i], 1'b0, 1'b0);
         n_cmp++; if (monState !== exp_st[i]) begin n_err++; $display("FAIL intr_state[%0d] got=%0d exp=%0d", i, monState, exp_st[i]); end
         n_cmp++; if (alarm !== (i == 5)) begin n_err++; $display("FAIL intr_alarm[%0d] got=%b exp=%b", i, alarm, (i == 5)); end
      end
      n_cmp++; if (episodeCount !== 8'd1) begin n_err++; $display("FAIL intr_count got=%0d exp=1", episodeCount); end
   endtask

   task automatic test_recover();
      logic       ab_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [1:0] exp_st [4] = '{2'd3, 2'd2, 2'd3, 2'd0};
      logic       exp_al [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      apply_reset();
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, ab_seq[i], 1'b0, 1'b0);
         n_cmp++; if (monState !== exp_st[i]) begin n_err++; $display("FAIL rec_state[%0d] got=%0d exp=%0d", i, monState, exp_st[i]); end
         n_cmp++; if (alarm !== exp_al[i]) begin n_err++; $display("FAIL rec_alarm[%0d] got=%b exp=%b", i, alarm, exp_al[i]); end
         n_cmp++; if (episodeCount !== 8'd1) begin n_err++; $display("FAIL rec_count[%0d] got=%0d exp=1", i, episodeCount); end
      end
   endtask

   task automatic test_gaps();
      logic [1:0] exp_st [3] = '{2'd1, 2'd1, 2'd2};
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0);
         for (int g = 0; g < 5; g++) drive(1'b0, g[0], 1'b0, 1'b0);
         n_cmp++; if (monState !== exp_st[i]) begin n_err++; $display("FAIL gap_state[%0d] got=%0d exp=%0d", i, monState, exp_st[i]); end
      end
      n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("FAIL gap_alarm got=%b exp=1", alarm); end
      n_cmp++; if (episodeCount !== 8'd1) begin n_err++; $display("FAIL gap_count got=%0d exp=1", episodeCount); end
      n_cmp++; if (alarmLatched !== 1'b1) begin n_err++; $display("FAIL gap_latch got=%b exp=1", alarmLatched); end
   endtask

   task automatic test_ack();
      apply_reset();
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      // episode start and ack together: set wins
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      n_cmp++; if (alarmLatched !== 1'b1) begin n_err++; $display("FAIL ack_same_latch got=%b exp=1", alarmLatched); end
      n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("FAIL ack_same_alarm got=%b exp=1", alarm); end
      // ack on a non-sample cycle clears only the latch
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (alarmLatched !== 1'b0) begin n_err++; $display("FAIL ack_next_latch got=%b exp=0", alarmLatched); end
      n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("FAIL ack_next_alarm got=%b exp=1", alarm); end
      n_cmp++; if (monState !== 2'd2) begin n_err++; $display("FAIL ack_next_state got=%0d exp=2", monState); end
   endtask

   task automatic test_saturation();
      apply_reset();
      for (int e = 0; e < 5; e++) begin
         for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
         for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
      end
      n_cmp++; if (episodeCount2 !== 2'd3) begin n_err++; $display("FAIL sat_count_w2 got=%0d exp=3", episodeCount2); end
      n_cmp++; if (episodeCount !== 8'd5) begin n_err++; $display("FAIL sat_count_w8 got=%0d exp=5", episodeCount); end
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (monState !== 2'd3) begin n_err++; $display("FAIL mid_recover_state got=%0d exp=3", monState); end
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      n_cmp++; if ({alarm, alarmLatched, episodeCount, monState} !== 12'd0) begin
         n_err++; $display("FAIL rst_recover_w8 got=%b/%b/%0d/%0d exp=0/0/0/0", alarm, alarmLatched, episodeCount, monState);
      end
      n_cmp++; if ({alarm2, alarmLatched2, episodeCount2, monState2} !== 6'd0) begin
         n_err++; $display("FAIL rst_recover_w2 got=%b/%b/%0d/%0d exp=0/0/0/0", alarm2, alarmLatched2, episodeCount2, monState2);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_interrupted_run();
      test_recover();
      test_gaps();
      test_ack();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
